// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style character-LCD refresh controller.
// FSM encodings, init command ROM, DDRAM address commands and counter sizing.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_ADDR1,
        ST_CHAR,
        ST_ADDR2,
        ST_FRAME
    } state_t;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_EHI,
        BUS_WAIT
    } bus_state_t;

    localparam logic [7:0] LCD_ADDR_L1 = 8'h80;
    localparam logic [7:0] LCD_ADDR_L2 = 8'hC0;
    localparam logic [7:0] LCD_CMD_CLR = 8'h01;
    localparam int         INIT_LEN    = 6;
    localparam int         SETUP_CYC   = 2;

    // Power-up command ROM: 8-bit/2-line function set x3, display on, entry mode, clear.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = 8'h38;
            3'd1:    c = 8'h38;
            3'd2:    c = 8'h38;
            3'd3:    c = 8'h0C;
            3'd4:    c = 8'h06;
            3'd5:    c = LCD_CMD_CLR;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Width of a counter able to reach the largest of the timing constants.
    function automatic int cnt_width(input int a, input int b,
                                     input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lcd_bus_write.sv
// One LCD bus write: SETUP (2 clk) -> EHI (lcd_e high) -> WAIT (command/clear time).
// Data is re-sampled on the last SETUP clock so a registered character source can settle.
module lcd_bus_write
    import lcd_pkg::*;
#(
    parameter int E_HIGH_CYC = 12,
    parameter int CMD_CYC    = 2000,
    parameter int CLR_CYC    = 82000,
    parameter int CW         = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EHI_LAST   = CW'(E_HIGH_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);

    bus_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          is_clr;
    logic [CW-1:0] wait_last;

    assign wait_last = is_clr ? CLR_LAST : CMD_LAST;

    // Phase sequencing and phase-length counting.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        done     = 1'b0;
        unique case (state)
            BUS_IDLE: begin
                cnt_nx = '0;
                if (start) state_nx = BUS_SETUP;
            end
            BUS_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nx = BUS_EHI;
                    cnt_nx   = '0;
                end
            end
            BUS_EHI: begin
                if (cnt == EHI_LAST) begin
                    state_nx = BUS_WAIT;
                    cnt_nx   = '0;
                end
            end
            BUS_WAIT: begin
                if (cnt == wait_last) begin
                    done     = 1'b1;
                    state_nx = BUS_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = BUS_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Phase register plus registered bus pins; data held through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BUS_IDLE;
            cnt      <= '0;
            is_clr   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            lcd_e <= (state_nx == BUS_EHI);
            if (state == BUS_IDLE && start) begin
                lcd_rs   <= rs;
                lcd_data <= data;
                is_clr   <= !rs && (data == LCD_CMD_CLR);
            end
            if (state == BUS_SETUP && cnt == SETUP_LAST) begin
                lcd_data <= data;
            end
        end
    end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Character-LCD refresh master: power-up wait, init commands, then endless 2x16 refresh.
// Optional LCD_REFRESH_HOLD_EN adds a hold input that parks the refresh at frame boundaries.
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC = 750000,
    parameter int E_HIGH_CYC  = 12,
    parameter int CMD_CYC     = 2000,
    parameter int CLR_CYC     = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
`ifdef LCD_REFRESH_HOLD_EN
    input  logic       hold,
`endif
    output logic [4:0] index,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    localparam int            CW       = cnt_width(POWERUP_CYC, CLR_CYC,
                                                   CMD_CYC, E_HIGH_CYC);
    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYC - 1);
    localparam logic [2:0]    INIT_LST = 3'(INIT_LEN - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    init_idx;
    logic [4:0]    pos;
    logic          busy;
    logic          start, done, park;
    logic          wr_rs;
    logic [7:0]    wr_cmd, wr_data;

`ifdef LCD_REFRESH_HOLD_EN
    assign park = hold;
`else
    assign park = 1'b0;
`endif

    assign lcd_rw  = 1'b0;
    assign wr_data = wr_rs ? char_in : wr_cmd;

    // Sequencer: each write state issues once, then advances on the write's done.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        wr_rs    = 1'b0;
        wr_cmd   = 8'h00;
        unique case (state)
            ST_PWRUP: begin
                if (cnt == PWR_LAST) state_nx = ST_INIT;
            end
            ST_INIT: begin
                wr_cmd = init_cmd(init_idx);
                start  = !busy;
                if (done && init_idx == INIT_LST) state_nx = ST_ADDR1;
            end
            ST_ADDR1: begin
                wr_cmd = LCD_ADDR_L1;
                start  = !busy;
                if (done) state_nx = ST_CHAR;
            end
            ST_CHAR: begin
                wr_rs = 1'b1;
                start = !busy;
                if (done && pos == 5'd15) state_nx = ST_ADDR2;
                if (done && pos == 5'd31) state_nx = ST_FRAME;
            end
            ST_ADDR2: begin
                wr_cmd = LCD_ADDR_L2;
                start  = !busy;
                if (done) state_nx = ST_CHAR;
            end
            ST_FRAME: begin
                if (!park) state_nx = ST_ADDR1;
            end
            default: state_nx = ST_PWRUP;
        endcase
    end

    // State, power-up counter, list position and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_PWRUP;
            cnt        <= '0;
            init_idx   <= '0;
            pos        <= '0;
            busy       <= 1'b0;
            index      <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state == ST_PWRUP) ? cnt + 1'b1 : '0;
            if (start) busy <= 1'b1;
            else if (done) busy <= 1'b0;
            if (state == ST_INIT && done) begin
                init_idx <= init_idx + 1'b1;
                if (init_idx == INIT_LST) init_done <= 1'b1;
            end
            if (state == ST_CHAR && start) index <= pos;
            if (state == ST_CHAR && done) pos <= pos + 1'b1;
            if (state_nx == ST_FRAME && state != ST_FRAME) index <= '0;
            frame_done <= (state_nx == ST_FRAME) && (state != ST_FRAME);
        end
    end

    lcd_bus_write #(
        .E_HIGH_CYC (E_HIGH_CYC),
        .CMD_CYC    (CMD_CYC),
        .CLR_CYC    (CLR_CYC),
        .CW         (CW)
    ) u_bus (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rs       (wr_rs),
        .data     (wr_data),
        .done     (done),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Self-checking bench for lcd_refresh_ctrl with shortened timing parameters.
// Build with LCD_REFRESH_HOLD_EN defined to also exercise the frame hold.
module tb_lcd_refresh_ctrl;

    localparam int P    = 20;
    localparam int EH   = 3;
    localparam int CMDW = 5;
    localparam int CLRW = 12;
    // e-low samples before a write: wait + 2 setup + 1 issue clock.
    localparam int GAP  = CMDW + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic [4:0] index;
    logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
    logic [7:0] lcd_data;
`ifdef LCD_REFRESH_HOLD_EN
    logic       hold = 1'b0;
`endif

    always #5 clk = ~clk;

    lcd_refresh_ctrl #(
        .POWERUP_CYC (P),
        .E_HIGH_CYC  (EH),
        .CMD_CYC     (CMDW),
        .CLR_CYC     (CLRW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
`ifdef LCD_REFRESH_HOLD_EN
        .hold       (hold),
`endif
        .index      (index),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    // Display list: registered lookup, one clock behind index.
    logic [7:0] list_mem [32];
    always @(posedge clk) char_in <= list_mem[index];

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic [4:0] idx;
        int         ehi;
        int         lo;
        logic       idn;
    } wr_t;

    typedef struct {
        string      name;
        logic       rs;
        logic [7:0] d;
        int         lo;
        logic       idn;
    } vec_t;

    wr_t  wq[$];
    int   hi_cnt, lo_cnt, cur_lo, id_gap, fd_gap, fd_pulses;
    int   stab_bad, rw_bad;
    logic prev_e, prev_id;
    logic [7:0] prev_d;

    int checks = 0;
    int failures = 0;

    initial begin
        hi_cnt = 0; lo_cnt = 0; cur_lo = 0; id_gap = -1; fd_gap = -1;
        fd_pulses = 0; stab_bad = 0; rw_bad = 0;
        prev_e = 1'b0; prev_id = 1'b0; prev_d = 8'h00;
    end

    // Bus monitor: one record per write, taken on the lcd_e falling edge.
    always @(negedge clk) begin
        if (rst) begin
            hi_cnt = 0; lo_cnt = 0; cur_lo = 0;
            prev_e = 1'b0; prev_id = 1'b0;
            wq.delete();
        end else begin
            if (lcd_rw !== 1'b0) rw_bad++;
            if (init_done && !prev_id) id_gap = lo_cnt;
            if (frame_done) begin
                fd_pulses++;
                fd_gap = lo_cnt;
            end
            if (lcd_e && prev_e && lcd_data !== prev_d) stab_bad++;
            if (lcd_e && !prev_e) begin
                cur_lo = lo_cnt;
                hi_cnt = 0;
            end
            if (!lcd_e && prev_e)
                wq.push_back('{lcd_rs, lcd_data, index, hi_cnt, cur_lo, init_done});
            if (lcd_e) begin
                hi_cnt++;
                lo_cnt = 0;
            end else begin
                lo_cnt++;
            end
            prev_e  = lcd_e;
            prev_id = init_done;
            prev_d  = lcd_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int t;
        t = 0;
        while (wq.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk($sformatf("write_count_%0d", n), 32'(wq.size() >= n), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_index"}, 32'(index), 0);
        chk({tag, "_lcd_e"}, 32'(lcd_e), 0);
        chk({tag, "_lcd_rs"}, 32'(lcd_rs), 0);
        chk({tag, "_lcd_rw"}, 32'(lcd_rw), 0);
        chk({tag, "_lcd_data"}, 32'(lcd_data), 0);
        chk({tag, "_init_done"}, 32'(init_done), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    // Expected init sequence plus the first line-1 address after clear.
    vec_t init_tbl[7];

    task automatic check_init(input string tag);
        for (int i = 0; i < 7; i++) begin
            wr_t w;
            w = (i < wq.size()) ? wq[i] : '{1'bx, 8'hxx, 5'hxx, -1, -1, 1'bx};
            chk($sformatf("%s_%s_rs", tag, init_tbl[i].name), 32'(w.rs), 32'(init_tbl[i].rs));
            chk($sformatf("%s_%s_data", tag, init_tbl[i].name), 32'(w.d), 32'(init_tbl[i].d));
            chk($sformatf("%s_%s_ehi", tag, init_tbl[i].name), 32'(w.ehi), 32'(EH));
            chk($sformatf("%s_%s_gap", tag, init_tbl[i].name), 32'(w.lo), 32'(init_tbl[i].lo));
            chk($sformatf("%s_%s_idone", tag, init_tbl[i].name), 32'(w.idn), 32'(init_tbl[i].idn));
        end
    endtask

    // Reference frame: 0x80, list[0..15], 0xC0, list[16..31].
    task automatic check_frame(input int base, input string tag);
        for (int k = 0; k < 34; k++) begin
            logic       e_rs;
            logic [7:0] e_d;
            int         p;
            wr_t        w;
            w = (base + k < wq.size()) ? wq[base + k] : '{1'bx, 8'hxx, 5'hxx, -1, -1, 1'bx};
            p = (k < 17) ? k - 1 : k - 2;
            if (k == 0) begin
                e_rs = 1'b0; e_d = 8'h80;
            end else if (k == 17) begin
                e_rs = 1'b0; e_d = 8'hC0;
            end else begin
                e_rs = 1'b1; e_d = list_mem[p];
            end
            chk($sformatf("%s_w%0d_rs", tag, k), 32'(w.rs), 32'(e_rs));
            chk($sformatf("%s_w%0d_data", tag, k), 32'(w.d), 32'(e_d));
            if (e_rs) chk($sformatf("%s_w%0d_index", tag, k), 32'(w.idx), 32'(p));
            if (k > 0) chk($sformatf("%s_w%0d_gap", tag, k), 32'(w.lo), 32'(GAP));
        end
    endtask

    task automatic randomize_list();
        for (int i = 0; i < 32; i++) list_mem[i] = 8'($urandom);
    endtask

    initial begin
        int t;
        bit seen;

        init_tbl[0] = '{"fs0", 1'b0, 8'h38, P + 2, 1'b0};
        init_tbl[1] = '{"fs1", 1'b0, 8'h38, GAP, 1'b0};
        init_tbl[2] = '{"fs2", 1'b0, 8'h38, GAP, 1'b0};
        init_tbl[3] = '{"don", 1'b0, 8'h0C, GAP, 1'b0};
        init_tbl[4] = '{"ent", 1'b0, 8'h06, GAP, 1'b0};
        init_tbl[5] = '{"clr", 1'b0, 8'h01, GAP, 1'b0};
        init_tbl[6] = '{"adr", 1'b0, 8'h80, CLRW + 3, 1'b1};
        for (int i = 0; i < 32; i++) list_mem[i] = 8'(8'h30 + i);

        // Reset state.
        #1;
        chk_outputs_zero("reset");
        repeat (3) tick();
        chk_outputs_zero("reset_hold");
        @(negedge clk);
        #1 rst = 1'b0;

        // Init sequence and first frame with list = 0x30 + index.
        wait_writes(41, 3000);
        check_init("init");
        chk("init_done_gap", 32'(id_gap), 32'(CLRW));
        check_frame(6, "frame1");
        chk("frame_done_pulses", 32'(fd_pulses), 1);
        chk("frame_done_gap", 32'(fd_gap), 32'(CMDW));
        chk("wrap_addr_data", 32'(wq[40].d), 32'h80);
        chk("wrap_addr_gap", 32'(wq[40].lo), 32'(CMDW + 4));
        chk("wrap_index", 32'(wq[40].idx), 0);

        // Random list contents, two more frames.
        randomize_list();
        wait_writes(75, 3000);
        check_frame(40, "frame2");
        randomize_list();
        wait_writes(109, 3000);
        check_frame(74, "frame3");
        chk("frame_done_pulses3", 32'(fd_pulses), 3);

        // Mid-frame reset at index 9.
        t = 0;
        while (!(index == 5'd9 && lcd_rs == 1'b1) && t < 3000) begin
            tick();
            t++;
        end
        chk("reach_index9", 32'(index), 9);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        tick();
        tick();
        chk_outputs_zero("midrst_hold");
        #1 rst = 1'b0;
        wait_writes(8, 3000);
        check_init("reinit");
        chk("reinit_first_rs", 32'(wq[7].rs), 1);
        chk("reinit_first_index", 32'(wq[7].idx), 0);
        chk("reinit_first_data", 32'(wq[7].d), 32'(list_mem[0]));

`ifdef LCD_REFRESH_HOLD_EN
        // Hold raised mid-frame: frame completes, then FSM parks.
        hold = 1'b1;
        t = fd_pulses;
        wait_writes(40, 3000);
        check_frame(6, "hold_frame");
        repeat (CMDW + 3) tick();
        chk("hold_one_pulse", 32'(fd_pulses), 32'(t + 1));
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (lcd_e) seen = 1'b1;
            tick();
        end
        chk("hold_bus_idle", 32'(seen), 0);
        chk("hold_no_writes", 32'(wq.size()), 40);
        chk("hold_no_repulse", 32'(fd_pulses), 32'(t + 1));
        hold = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin
            tick();
            if (lcd_rs == 1'b0 && lcd_data == 8'h80) seen = 1'b1;
        end
        chk("release_addr_within_3", 32'(seen), 1);
        wait_writes(41, 200);
        chk("release_addr_data", 32'(wq[40].d), 32'h80);
`endif

        chk("data_stable_while_e", 32'(stab_bad), 0);
        chk("rw_always_zero", 32'(rw_bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
